// File: rtl/nv_nvdla_core_soft_reset_seq.sv
// Software-initiated core reset sequencer: fence new traffic, drain, pulse core_reset_rstn,
// then wait for the synchronized core reset to return before reporting completion.
`timescale 1ns/1ps
module nv_nvdla_core_soft_reset_seq #(
  parameter int unsigned ASSERT_CYCLES   = 16,
  parameter int unsigned DRAIN_TIMEOUT   = 1024,
  parameter int unsigned RELEASE_TIMEOUT = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic nvdla_clk,
  input  logic synced_dla_rstn,
  input  logic sw_reset_req,
  input  logic core_idle,
  input  logic synced_rstn,
  input  logic err_clr,
  output logic core_reset_rstn,
  output logic fence_req,
  output logic reset_busy,
  output logic reset_done,
  output logic drain_timeout,
  output logic release_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FENCE,
    S_ASSERT,
    S_RELEASE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             pending_q, pending_d;
  logic             core_reset_rstn_q, core_reset_rstn_d;
  logic             fence_req_q, fence_req_d;
  logic             reset_busy_q, reset_busy_d;
  logic             reset_done_q, reset_done_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic             release_timeout_q, release_timeout_d;

  always_comb begin
    timer_inc         = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);
    state_d           = state_q;
    timer_d           = timer_inc;
    pending_d         = pending_q | (sw_reset_req && (state_q != S_IDLE));
    drain_timeout_d   = drain_timeout_q & ~err_clr;
    release_timeout_d = release_timeout_q & ~err_clr;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (sw_reset_req || pending_q) begin
          state_d   = S_FENCE;
          pending_d = 1'b0;
        end
      end
      S_FENCE: begin
        // A drained core on the final timer cycle is a clean exit, not a timeout.
        if (core_idle) begin
          state_d = S_ASSERT;
        end else if (timer_q == DRAIN_LAST) begin
          state_d         = S_ASSERT;
          drain_timeout_d = 1'b1;
        end
      end
      S_ASSERT: begin
        // The minimum pulse is only timed once the reset stage reports reset asserted.
        if (synced_rstn) begin
          timer_d = timer_q;
        end else if (timer_q == ASSERT_LAST) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (synced_rstn) begin
          state_d = S_DONE;
        end else if (timer_q == RELEASE_LAST) begin
          state_d           = S_DONE;
          release_timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end

    core_reset_rstn_d = (state_d != S_ASSERT);
    fence_req_d       = (state_d == S_FENCE) || (state_d == S_ASSERT) || (state_d == S_RELEASE);
    reset_busy_d      = (state_d != S_IDLE);
    reset_done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge nvdla_clk or negedge synced_dla_rstn) begin
    if (!synced_dla_rstn) begin
      state_q           <= S_IDLE;
      timer_q           <= '0;
      pending_q         <= 1'b0;
      core_reset_rstn_q <= 1'b1;
      fence_req_q       <= 1'b0;
      reset_busy_q      <= 1'b0;
      reset_done_q      <= 1'b0;
      drain_timeout_q   <= 1'b0;
      release_timeout_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      pending_q         <= pending_d;
      core_reset_rstn_q <= core_reset_rstn_d;
      fence_req_q       <= fence_req_d;
      reset_busy_q      <= reset_busy_d;
      reset_done_q      <= reset_done_d;
      drain_timeout_q   <= drain_timeout_d;
      release_timeout_q <= release_timeout_d;
    end
  end

  assign core_reset_rstn = core_reset_rstn_q;
  assign fence_req       = fence_req_q;
  assign reset_busy      = reset_busy_q;
  assign reset_done      = reset_done_q;
  assign drain_timeout   = drain_timeout_q;
  assign release_timeout = release_timeout_q;

endmodule

// File: tb/tb_nv_nvdla_core_soft_reset_seq.sv
// Scoreboard bench: each request pushes the predicted phase lengths and flags; a monitor
// measures every completed sequence and compares it on the reset_done pulse.
`timescale 1ns/1ps
module tb_nv_nvdla_core_soft_reset_seq;

  localparam int AC = 16;
  localparam int DT = 1024;
  localparam int RT = 64;

  logic nvdla_clk       = 1'b0;
  logic synced_dla_rstn = 1'b1;
  logic sw_reset_req    = 1'b0;
  logic core_idle       = 1'b0;
  logic synced_rstn     = 1'b1;
  logic err_clr         = 1'b0;
  logic core_reset_rstn, fence_req, reset_busy, reset_done, drain_timeout, release_timeout;

  nv_nvdla_core_soft_reset_seq #(
    .ASSERT_CYCLES(AC), .DRAIN_TIMEOUT(DT), .RELEASE_TIMEOUT(RT), .CNT_W(16)
  ) dut (
    .nvdla_clk(nvdla_clk),
    .synced_dla_rstn(synced_dla_rstn),
    .sw_reset_req(sw_reset_req),
    .core_idle(core_idle),
    .synced_rstn(synced_rstn),
    .err_clr(err_clr),
    .core_reset_rstn(core_reset_rstn),
    .fence_req(fence_req),
    .reset_busy(reset_busy),
    .reset_done(reset_done),
    .drain_timeout(drain_timeout),
    .release_timeout(release_timeout)
  );

  always #5 nvdla_clk = ~nvdla_clk;

  typedef struct {
    int fence_len;
    int low_len;
    int rel_len;
    bit drain;
    bit rel;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   exp_drain = 0;
  bit   exp_rel = 0;

  // Environment knobs: core drains idle_k cycles into the fence; the reset stage sees the
  // request lf cycles after it falls and releases lr cycles after it rises.
  int idle_k = 0;
  int lf = 0;
  int lr = 0;
  int f_cnt = 0;
  int a_cnt = 0;
  int r_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge nvdla_clk) begin
    if (fence_req) begin
      core_idle = (f_cnt >= idle_k);
      f_cnt++;
    end else begin
      f_cnt = 0;
      core_idle = 1'($urandom_range(0, 1));
    end
    if (!core_reset_rstn) begin
      synced_rstn = (a_cnt < lf);
      a_cnt++;
      r_cnt = 0;
    end else begin
      a_cnt = 0;
      if (!synced_rstn) begin
        if (r_cnt >= lr) synced_rstn = 1'b1;
        r_cnt++;
      end
    end
  end

  // Monitor: measures fence, low-pulse and release lengths of each sequence.
  int m_f = 0;
  int m_l = 0;
  int m_r = 0;
  bit m_low = 0;
  bit m_after = 0;

  always @(negedge nvdla_clk) begin
    if (!synced_dla_rstn) begin
      m_f = 0; m_l = 0; m_r = 0; m_low = 0; m_after = 0;
    end else begin
      if (m_after) begin
        check("done_pulse_width", reset_done, 0);
        check("busy_after_done", reset_busy, 0);
        m_after = 0;
      end
      if (fence_req && core_reset_rstn && !m_low) m_f++;
      if (!core_reset_rstn) begin
        m_l++;
        m_low = 1;
      end
      if (fence_req && core_reset_rstn && m_low) m_r++;
      if (reset_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("fence_len", m_f, mon_e.fence_len);
          check("rstn_low_len", m_l, mon_e.low_len);
          check("release_len", m_r, mon_e.rel_len);
          check("drain_timeout_at_done", drain_timeout, mon_e.drain);
          check("release_timeout_at_done", release_timeout, mon_e.rel);
          check("fence_in_done", fence_req, 0);
          check("rstn_in_done", core_reset_rstn, 1);
          check("busy_in_done", reset_busy, 1);
        end
        m_f = 0; m_l = 0; m_r = 0; m_low = 0; m_after = 1;
      end
    end
  end

  // Reference model: phase lengths follow directly from the environment knobs.
  task automatic push_seq();
    exp_t e;
    e.fence_len = (idle_k < DT) ? idle_k + 1 : DT;
    e.low_len   = lf + AC;
    e.rel_len   = (lr < RT) ? lr + 1 : RT;
    if (idle_k >= DT) exp_drain = 1;
    if (lr >= RT) exp_rel = 1;
    e.drain = exp_drain;
    e.rel   = exp_rel;
    sb_q.push_back(e);
  endtask

  task automatic wait_quiet(input int budget);
    int i;
    i = 0;
    while ((reset_busy || !synced_rstn || sb_q.size() != 0) && i < budget) begin
      @(negedge nvdla_clk);
      i++;
    end
    check("sequence_completes", (reset_busy || !synced_rstn || sb_q.size() != 0), 0);
    sb_q.delete();
    repeat (2) @(negedge nvdla_clk);
  endtask

  task automatic wait_low(input int budget);
    int i;
    i = 0;
    while (core_reset_rstn && i < budget) begin
      @(negedge nvdla_clk);
      i++;
    end
    check("reached_assert", core_reset_rstn, 0);
  endtask

  task automatic request(input int k, input int f, input int r, input int extra);
    idle_k = k; lf = f; lr = r;
    @(negedge nvdla_clk);
    push_seq();
    sw_reset_req = 1'b1;
    @(negedge nvdla_clk);
    sw_reset_req = 1'b0;
    check("req_to_fence", fence_req, 1);
    check("req_to_busy", reset_busy, 1);
    if (extra > 0) begin
      wait_low(2 * DT + 100);
      push_seq();
      for (int p = 0; p < extra; p++) begin
        sw_reset_req = 1'b1;
        @(negedge nvdla_clk);
        sw_reset_req = 1'b0;
        @(negedge nvdla_clk);
      end
    end
    wait_quiet(3 * DT + 1000);
    check("sticky_drain", drain_timeout, exp_drain);
    check("sticky_release", release_timeout, exp_rel);
  endtask

  task automatic clear_errs();
    @(negedge nvdla_clk);
    err_clr = 1'b1;
    @(negedge nvdla_clk);
    err_clr = 1'b0;
    exp_drain = 0;
    exp_rel = 0;
    check("clr_drain", drain_timeout, 0);
    check("clr_release", release_timeout, 0);
  endtask

  initial begin
    int sel, k, f, r, ex;
    bit saw_busy;
    #1 synced_dla_rstn = 1'b0;
    repeat (3) @(negedge nvdla_clk);
    check("rst_core_reset_rstn", core_reset_rstn, 1);
    check("rst_fence_req", fence_req, 0);
    check("rst_reset_busy", reset_busy, 0);
    check("rst_reset_done", reset_done, 0);
    check("rst_drain_timeout", drain_timeout, 0);
    check("rst_release_timeout", release_timeout, 0);
    #2 synced_dla_rstn = 1'b1;
    repeat (2) @(negedge nvdla_clk);

    // Drained core, reset stage lagging 3 cycles each way.
    request(0, 3, 3, 0);
    // Core never drains: fence times out but reset is still applied.
    request(5000, 2, 2, 0);
    clear_errs();
    // Reset stage stuck low well past the release window.
    request(2, 1, 200, 0);
    clear_errs();
    // Three extra requests during ASSERT merge into one more sequence.
    request(4, 2, 5, 3);
    saw_busy = 0;
    repeat (10) begin
      @(negedge nvdla_clk);
      if (reset_busy) saw_busy = 1;
    end
    check("no_third_sequence", saw_busy, 0);

    // Abort mid-ASSERT with a request pending.
    idle_k = 0; lf = 2; lr = 3;
    @(negedge nvdla_clk);
    sw_reset_req = 1'b1;
    @(negedge nvdla_clk);
    sw_reset_req = 1'b0;
    wait_low(100);
    sw_reset_req = 1'b1;
    @(negedge nvdla_clk);
    sw_reset_req = 1'b0;
    #2 synced_dla_rstn = 1'b0;
    #1;
    check("abort_rstn", core_reset_rstn, 1);
    check("abort_fence", fence_req, 0);
    check("abort_busy", reset_busy, 0);
    check("abort_done", reset_done, 0);
    sb_q.delete();
    exp_drain = 0;
    exp_rel = 0;
    repeat (3) @(negedge nvdla_clk);
    #2 synced_dla_rstn = 1'b1;
    saw_busy = 0;
    repeat (20) begin
      @(negedge nvdla_clk);
      if (reset_busy) saw_busy = 1;
    end
    check("pending_cleared_by_reset", saw_busy, 0);
    request(0, 3, 3, 0);

    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 9);
      k = (sel == 0) ? DT - 1 : (sel == 1) ? DT : (sel == 2) ? 1500 : $urandom_range(0, 30);
      f = $urandom_range(0, 8);
      r = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 20);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (ex > 0 && r > 50) r = 10;
      request(k, f, r, ex);
      if ($urandom_range(0, 2) == 0) clear_errs();
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
